beat_sequencer: RTL and testbench

Downstream consumer of the beat generator's one-cycle `pulse`. On each beat it advances a step pointer through a STEPS-long on/off pattern and emits a stretched, fixed-length gate for active steps (LED/tone/drum trigger). It also emits an accent on step 0 and a one-cycle bar-start marker. Its `restart` input is driven by the switch handler's tempo-change reset, so the pattern realigns to step 0 whenever the tempo changes.

---
 rtl/beat_pkg.sv | 19 +
 rtl/gate_timer.sv | 41 ++++
 rtl/beat_sequencer.sv | 150 +++++++++++++++
 tb/tb_beat_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beat_pkg.sv
// -----------------------------------------------------------------------------
// beat_pkg
// Shared definitions for the beat sequencer slice: sequencer state encoding,
// the system clock rate and the default pattern length / gate width.
// -----------------------------------------------------------------------------
package beat_pkg;

    localparam int CLK_HZ              = 100_000_000;
    localparam int DEFAULT_STEPS       = 8;
    // 100 ms gate at CLK_HZ
    localparam int DEFAULT_GATE_CYCLES = 10_000_000;

    typedef enum logic [1:0] {
        STOPPED   = 2'd0,
        WAIT_BEAT = 2'd1,
        GATING    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/gate_timer.sv
// -----------------------------------------------------------------------------
// gate_timer
// Down-counter that times the gate high period. A load writes load_val into
// the counter. Otherwise the counter counts down and then holds at zero.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high; clears the counter
//   load     in   write load_val into the counter this cycle
//   load_val in   CW-bit reload value (GATE_CYCLES-1 to start a gate, 0 to clear)
//   expired  out  counter is zero
// -----------------------------------------------------------------------------
module gate_timer
    import beat_pkg::*;
#(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] count_q;

    // NOTE: clocked state is written with non-blocking (<=) assignments so every
    // register samples pre-edge values; blocking here would create order races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
// On each beat, advances a step pointer through a STEPS-long on/off pattern.
// For active steps it drives a stretched gate of GATE_CYCLES clocks. It flags
// step 0 with an accent (while gated) and with a one-cycle bar_start marker.
// A restart realigns the pointer to step 0.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high; clears all state
//   beat      in   one-cycle beat pulse
//   restart   in   one-cycle synchronous realign request
//   run       in   level; 1 = play, 0 = stopped
//   pattern   in   STEPS bits; bit i = 1 means step i fires
//   step      out  index of the most recently played step
//   gate      out  stretched trigger for an active step
//   accent    out  high with gate when the played step is 0
//   bar_start out  one-cycle pulse whenever step 0 is played
// -----------------------------------------------------------------------------
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int STEPS       = DEFAULT_STEPS,
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CW          = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     beat,
    input  logic                     restart,
    input  logic                     run,
    input  logic [STEPS-1:0]         pattern,
    output logic [$clog2(STEPS)-1:0] step,
    output logic                     gate,
    output logic                     accent,
    output logic                     bar_start
);

    localparam int            SW          = $clog2(STEPS);
    localparam logic [CW-1:0] GATE_RELOAD = CW'(GATE_CYCLES - 1);

    seq_state_t    state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] step_q, step_d;
    logic          gate_q, gate_d;
    logic          accent_q, accent_d;
    logic          bar_q, bar_d;

    logic          timer_load;
    logic [CW-1:0] timer_val;
    logic          expired;

    // A beat is played only while running and not overridden by restart or stop.
    logic play;
    assign play = beat && run && !restart && (state_q != STOPPED);

    gate_timer #(.CW(CW)) u_gate_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (expired)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= STOPPED;
            ptr_q    <= '0;
            step_q   <= '0;
            gate_q   <= 1'b0;
            accent_q <= 1'b0;
            bar_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            step_q   <= step_d;
            gate_q   <= gate_d;
            accent_q <= accent_d;
            bar_q    <= bar_d;
        end
    end

    // Next state. Priority: restart > run=0 > beat > expiry.
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = run ? WAIT_BEAT : STOPPED;
        end else if (!run) begin
            state_d = STOPPED;
        end else begin
            unique case (state_q)
                STOPPED:   state_d = WAIT_BEAT;
                WAIT_BEAT,
                GATING: begin
                    if (beat) begin
                        state_d = pattern[ptr_q] ? GATING : WAIT_BEAT;
                    end else if (state_q == GATING && expired) begin
                        state_d = WAIT_BEAT;
                    end
                end
                default:   state_d = STOPPED;
            endcase
        end
    end

    // Next output values and timer control
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned; a missing default here would infer a latch.
        ptr_d      = ptr_q;
        step_d     = step_q;
        gate_d     = gate_q;
        accent_d   = accent_q;
        bar_d      = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;

        if (restart || !run) begin
            // Realign or stop: drop the gate and clear the timer. step holds.
            ptr_d      = '0;
            gate_d     = 1'b0;
            accent_d   = 1'b0;
            timer_load = 1'b1;
        end else if (play) begin
            step_d = ptr_q;
            bar_d  = (ptr_q == '0);
            ptr_d  = ptr_q + 1'b1;   // STEPS is a power of two, so this wraps naturally
            timer_load = 1'b1;
            if (pattern[ptr_q]) begin
                // A beat on an active step retriggers with no low gap.
                gate_d    = 1'b1;
                accent_d  = (ptr_q == '0);
                timer_val = GATE_RELOAD;
            end else begin
                gate_d   = 1'b0;
                accent_d = 1'b0;
            end
        end else if (state_q == GATING && expired) begin
            gate_d   = 1'b0;
            accent_d = 1'b0;
        end
    end

    assign step      = step_q;
    assign gate      = gate_q;
    assign accent    = accent_q;
    assign bar_start = bar_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
// Self-checking bench for beat_sequencer (STEPS=8, GATE_CYCLES=4). A reference
// model tracks the next step, the run state and the number of gate-high cycles
// left. Outputs are compared with the model one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

    localparam int STEPS       = 8;
    localparam int GATE_CYCLES = 4;
    localparam int CW          = 24;
    localparam int SW          = $clog2(STEPS);

    logic             clk = 1'b0;
    logic             reset;
    logic             beat;
    logic             restart;
    logic             run;
    logic [STEPS-1:0] pattern;
    logic [SW-1:0]    step;
    logic             gate;
    logic             accent;
    logic             bar_start;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_next;      // next step to be played
    int m_last;      // last played step
    int m_left;      // gate-high cycles remaining, including the current one
    bit m_acc;       // last played step was step 0
    bit m_bar;
    bit m_running;

    always #5 clk = ~clk;

    beat_sequencer #(
        .STEPS       (STEPS),
        .GATE_CYCLES (GATE_CYCLES),
        .CW          (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .beat      (beat),
        .restart   (restart),
        .run       (run),
        .pattern   (pattern),
        .step      (step),
        .gate      (gate),
        .accent    (accent),
        .bar_start (bar_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_next    = 0;
        m_last    = 0;
        m_left    = 0;
        m_acc     = 1'b0;
        m_bar     = 1'b0;
        m_running = 1'b0;
    endtask

    // One clock edge of the reference behaviour
    task automatic model_step(input bit b, input bit r, input bit rn, input logic [STEPS-1:0] pat);
        m_bar = 1'b0;
        if (r) begin
            m_next    = 0;
            m_left    = 0;
            m_running = rn;
        end else if (!rn) begin
            m_running = 1'b0;
            m_next    = 0;
            m_left    = 0;
        end else if (!m_running) begin
            m_running = 1'b1;
        end else if (b) begin
            m_last = m_next;
            m_bar  = (m_next == 0);
            m_acc  = (m_next == 0);
            m_left = pat[m_next] ? GATE_CYCLES : 0;
            m_next = (m_next + 1) % STEPS;
        end else if (m_left > 0) begin
            m_left--;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_step"},   32'(step),      32'(m_last));
        check({tag, "_gate"},   32'(gate),      32'(m_left > 0));
        check({tag, "_accent"}, 32'(accent),    32'((m_left > 0) && m_acc));
        check({tag, "_bar"},    32'(bar_start), 32'(m_bar));
    endtask

    // Apply one cycle of inputs, advance the model, then compare
    task automatic tick(input bit b, input bit r, input string tag);
        beat    = b;
        restart = r;
        @(posedge clk);
        model_step(b, r, run, pattern);
        #1;
        check_all(tag);
        beat    = 1'b0;
        restart = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, tag);
    endtask

    initial begin
        int highs;
        int lows;
        logic [SW-1:0] held_step;

        reset   = 1'b1;
        beat    = 1'b0;
        restart = 1'b0;
        run     = 1'b0;
        pattern = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #2 reset = 1'b0;

        // 1: sparse pattern, beats every 10 cycles, nine beats to show the wrap
        pattern = 8'b1000_0101;
        run     = 1'b1;
        tick(1'b0, 1'b0, "p1_start");
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b0, "p1_beat");
            check("p1_step_seq", 32'(step), 32'(i % STEPS));
            check("p1_bar_seq",  32'(bar_start), 32'((i % STEPS) == 0));
            check("p1_acc_seq",  32'(accent), 32'((i % STEPS) == 0));
            highs = int'(gate);
            for (int k = 0; k < 9; k++) begin
                tick(1'b0, 1'b0, "p1_idle");
                highs += int'(gate);
            end
            check("p1_gate_width", 32'(highs), pattern[i % STEPS] ? 32'(GATE_CYCLES) : 32'd0);
        end

        // 2: all steps active, beats every 3 cycles -> continuous gate
        pattern = 8'hFF;
        tick(1'b0, 1'b1, "p2_align");
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, "p2_beat");
            lows += int'(!gate);
            check("p2_step_seq", 32'(step), 32'(i % STEPS));
            if (i < 9) begin
                for (int k = 0; k < 2; k++) begin
                    tick(1'b0, 1'b0, "p2_idle");
                    lows += int'(!gate);
                end
            end
        end
        check("p2_gate_continuous_lows", 32'(lows), 32'd0);
        highs = 1;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, "p2_tail");
            highs += int'(gate);
        end
        check("p2_tail_width", 32'(highs), 32'(GATE_CYCLES));

        // 3: beat coincident with expiry (every 4 cycles)
        tick(1'b0, 1'b1, "p3_align");
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, "p3_beat");
            lows += int'(!gate);
            for (int k = 0; k < 3; k++) begin
                tick(1'b0, 1'b0, "p3_idle");
                lows += int'(!gate);
            end
        end
        check("p3_never_drops", 32'(lows), 32'd0);
        pattern = 8'h01;
        tick(1'b0, 1'b1, "p3b_align");
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, "p3b_beat");
            idle(3, "p3b_idle");
        end

        // 4: realign with a coincident beat while ptr=5
        pattern = 8'b1010_0111;
        tick(1'b0, 1'b1, "p4_align");
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, "p4_beat");
            idle(1, "p4_idle");
        end
        held_step = step;
        tick(1'b1, 1'b1, "p4_restart");
        check("p4_restart_gate", 32'(gate), 32'd0);
        check("p4_restart_step_holds", 32'(step), 32'(held_step));
        idle(2, "p4_idle2");
        tick(1'b1, 1'b0, "p4_first");
        check("p4_first_step", 32'(step), 32'd0);
        check("p4_first_bar",  32'(bar_start), 32'd1);
        check("p4_first_gate", 32'(gate), 32'(pattern[0]));

        // 5: stop mid-gate, beats while stopped, resume at step 0
        pattern = 8'hFF;
        tick(1'b1, 1'b0, "p5_beat");
        idle(1, "p5_idle");
        run = 1'b0;
        tick(1'b0, 1'b0, "p5_stop");
        check("p5_stop_gate", 32'(gate), 32'd0);
        held_step = step;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, "p5_stopped_beat");
            idle(1, "p5_stopped_idle");
        end
        check("p5_step_held", 32'(step), 32'(held_step));
        run = 1'b1;
        tick(1'b0, 1'b0, "p5_resume");
        tick(1'b1, 1'b0, "p5_first");
        check("p5_first_step", 32'(step), 32'd0);

        // 6: asynchronous reset mid-gate, between clock edges
        tick(1'b1, 1'b0, "p6_beat");
        tick(1'b1, 1'b0, "p6_beat2");
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("p6_async");
        check("p6_async_gate", 32'(gate), 32'd0);
        check("p6_async_step", 32'(step), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        tick(1'b0, 1'b0, "p6_start");
        tick(1'b1, 1'b0, "p6_first");
        check("p6_first_step", 32'(step), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (run ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 4) == 0))
                run = ~run;
            if ($urandom_range(0, 99) == 0)
                pattern = STEPS'($urandom);
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
